// File: rtl/sdram_arbit.sv
// SDRAM bus arbiter: init, then fixed-priority refresh > write > read.
// Optional watchdog enabled by macro SDRAM_ARBIT_WDOG_EN.
module sdram_arbit #(
  parameter logic [3:0] CMD_NOP = 4'b0111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flag_init_end,
  input  logic [3:0]  init_cmd,
  input  logic [12:0] init_addr,
  input  logic        aref_req,
  input  logic        flag_aref_end,
  input  logic [3:0]  aref_cmd,
  input  logic [12:0] aref_addr,
  input  logic        wr_req,
  input  logic        flag_wr_end,
  input  logic [3:0]  wr_cmd,
  input  logic [12:0] wr_addr,
  input  logic [1:0]  wr_ba,
  input  logic        rd_req,
  input  logic        flag_rd_end,
  input  logic [3:0]  rd_cmd,
  input  logic [12:0] rd_addr,
  input  logic [1:0]  rd_ba,
  output logic        aref_en,
  output logic        wr_en,
  output logic        rd_en,
  output logic [3:0]  sdram_cmd,
  output logic [12:0] sdram_addr,
  output logic [1:0]  sdram_ba
);

  typedef enum logic [2:0] {
    INIT, ARBIT, AREF, WRITE, READ
  } state_t;

  state_t state, next;
  logic   wdog;

`ifdef SDRAM_ARBIT_WDOG_EN
  localparam logic [9:0] WDOG_LAST = 10'd1022;
  logic [9:0] cnt;

  // counts cycles spent in an operation; a stuck owner is evicted
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (state == AREF || state == WRITE || state == READ)
      cnt <= cnt + 10'd1;
    else
      cnt <= '0;
  end

  assign wdog = (cnt == WDOG_LAST);
`else
  assign wdog = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= INIT;
    else     state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      INIT:  if (flag_init_end) next = ARBIT;
      ARBIT: begin
        if (aref_req)    next = AREF;
        else if (wr_req) next = WRITE;
        else if (rd_req) next = READ;
      end
      AREF:  if (flag_aref_end || wdog) next = ARBIT;
      WRITE: if (flag_wr_end || wdog)   next = ARBIT;
      READ:  if (flag_rd_end || wdog)   next = ARBIT;
      default: next = INIT;
    endcase
  end

  always_comb begin
    aref_en    = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    sdram_cmd  = CMD_NOP;
    sdram_addr = '0;
    sdram_ba   = '0;
    unique case (state)
      INIT: begin
        sdram_cmd  = init_cmd;
        sdram_addr = init_addr;
      end
      AREF: begin
        aref_en    = 1'b1;
        sdram_cmd  = aref_cmd;
        sdram_addr = aref_addr;
      end
      WRITE: begin
        wr_en      = 1'b1;
        sdram_cmd  = wr_cmd;
        sdram_addr = wr_addr;
        sdram_ba   = wr_ba;
      end
      READ: begin
        rd_en      = 1'b1;
        sdram_cmd  = rd_cmd;
        sdram_addr = rd_addr;
        sdram_ba   = rd_ba;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sdram_arbit.sv
// Scoreboard bench for sdram_arbit: scripted per-cycle expectations.
module tb_sdram_arbit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flag_init_end = 1'b0;
  logic [3:0]  init_cmd = 4'h1;
  logic [12:0] init_addr = 13'h0111;
  logic        aref_req = 1'b0;
  logic        flag_aref_end = 1'b0;
  logic [3:0]  aref_cmd = 4'h2;
  logic [12:0] aref_addr = 13'h0222;
  logic        wr_req = 1'b0;
  logic        flag_wr_end = 1'b0;
  logic [3:0]  wr_cmd = 4'h4;
  logic [12:0] wr_addr = 13'h0444;
  logic [1:0]  wr_ba = 2'b01;
  logic        rd_req = 1'b0;
  logic        flag_rd_end = 1'b0;
  logic [3:0]  rd_cmd = 4'h5;
  logic [12:0] rd_addr = 13'h0555;
  logic [1:0]  rd_ba = 2'b10;
  logic        aref_en, wr_en, rd_en;
  logic [3:0]  sdram_cmd;
  logic [12:0] sdram_addr;
  logic [1:0]  sdram_ba;

  sdram_arbit dut (
    .clk(clk), .rst(rst),
    .flag_init_end(flag_init_end), .init_cmd(init_cmd),
    .init_addr(init_addr),
    .aref_req(aref_req), .flag_aref_end(flag_aref_end),
    .aref_cmd(aref_cmd), .aref_addr(aref_addr),
    .wr_req(wr_req), .flag_wr_end(flag_wr_end),
    .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_ba(wr_ba),
    .rd_req(rd_req), .flag_rd_end(flag_rd_end),
    .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_ba(rd_ba),
    .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en),
    .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr),
    .sdram_ba(sdram_ba)
  );

  always #5 clk = ~clk;

  localparam logic [7:0] S_NONE = 8'h00;
  localparam logic [7:0] S_RST = 8'h80;
  localparam logic [7:0] S_IE  = 8'h40;
  localparam logic [7:0] S_AR  = 8'h20;
  localparam logic [7:0] S_AE  = 8'h10;
  localparam logic [7:0] S_WQ  = 8'h08;
  localparam logic [7:0] S_WE  = 8'h04;
  localparam logic [7:0] S_RQ  = 8'h02;
  localparam logic [7:0] S_RE  = 8'h01;

  localparam logic [21:0] E_INIT = {3'b000, 4'h1, 13'h0111, 2'b00};
  localparam logic [21:0] E_ARB  = {3'b000, 4'b0111, 13'h0000, 2'b00};
  localparam logic [21:0] E_AREF = {3'b100, 4'h2, 13'h0222, 2'b00};
  localparam logic [21:0] E_RD   = {3'b001, 4'h5, 13'h0555, 2'b10};

  wire [21:0] obs = {aref_en, wr_en, rd_en, sdram_cmd, sdram_addr, sdram_ba};

  logic [21:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [21:0] e_wr();
    return {3'b010, 4'h4, 13'h0444, wr_ba};
  endfunction

  function automatic logic [29:0] row(logic [7:0] s, logic [21:0] e);
    return {s, e};
  endfunction

  task automatic apply(input logic [7:0] s);
    rst           = s[7];
    flag_init_end = s[6];
    aref_req      = s[5];
    flag_aref_end = s[4];
    wr_req        = s[3];
    flag_wr_end   = s[2];
    rd_req        = s[1];
    flag_rd_end   = s[0];
  endtask

  task automatic test_reset();
    logic [29:0] rows [$];
    logic [21:0] e;
    repeat (3) rows.push_back(row(S_RST, E_INIT));
    repeat (20) rows.push_back(row(S_NONE, E_INIT));
    rows.push_back(row(S_IE, E_ARB));
    rows.push_back(row(S_NONE, E_ARB));
    rows.push_back(row(S_IE, E_ARB));
    for (int i = 0; i < rows.size(); i++) begin
      apply(rows[i][29:22]);
      exp_q.push_back(rows[i][21:0]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL reset[%0d] got %h want %h", i, obs, e);
      end
    end
  endtask

  task automatic test_priority();
    logic [29:0] rows [$];
    logic [21:0] e;
    rows.push_back(row(S_AR | S_WQ | S_RQ, E_AREF));
    repeat (6) rows.push_back(row(S_WQ | S_RQ, E_AREF));
    rows.push_back(row(S_AE | S_WQ | S_RQ, E_ARB));
    rows.push_back(row(S_WQ | S_RQ, e_wr()));
    repeat (3) rows.push_back(row(S_RQ, e_wr()));
    rows.push_back(row(S_WE | S_RQ, E_ARB));
    rows.push_back(row(S_RQ, E_RD));
    rows.push_back(row(S_RE, E_ARB));
    rows.push_back(row(S_NONE, E_ARB));
    for (int i = 0; i < rows.size(); i++) begin
      apply(rows[i][29:22]);
      exp_q.push_back(rows[i][21:0]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL priority[%0d] got %h want %h", i, obs, e);
      end
    end
  endtask

  task automatic test_no_preempt();
    logic [29:0] rows [$];
    logic [21:0] e;
    rows.push_back(row(S_RQ, E_RD));
    rows.push_back(row(S_WQ, E_RD));
    rows.push_back(row(S_WQ | S_WE, E_RD));
    rows.push_back(row(S_WQ | S_AE | S_IE, E_RD));
    repeat (2) rows.push_back(row(S_WQ, E_RD));
    rows.push_back(row(S_WQ | S_RE, E_ARB));
    rows.push_back(row(S_WQ, e_wr()));
    rows.push_back(row(S_RE | S_AE, e_wr()));
    rows.push_back(row(S_WE, E_ARB));
    rows.push_back(row(S_NONE, E_ARB));
    for (int i = 0; i < rows.size(); i++) begin
      apply(rows[i][29:22]);
      exp_q.push_back(rows[i][21:0]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL no_preempt[%0d] got %h want %h", i, obs, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [29:0] rows [$];
    logic [21:0] e;
    wr_ba = 2'b11;
    rows.push_back(row(S_WQ, e_wr()));
    rows.push_back(row(S_NONE, e_wr()));
    rows.push_back(row(S_RST, E_INIT));
    repeat (5) rows.push_back(row(S_WQ | S_WE, E_INIT));
    rows.push_back(row(S_IE, E_ARB));
    rows.push_back(row(S_NONE, E_ARB));
    for (int i = 0; i < rows.size(); i++) begin
      apply(rows[i][29:22]);
      exp_q.push_back(rows[i][21:0]);
      if (rows[i][29]) begin
        #1;
        n_cmp++;
        if (obs !== E_INIT) begin
          n_err++;
          $display("FAIL reset_async got %h want %h", obs, E_INIT);
        end
      end
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL reset_mid[%0d] got %h want %h", i, obs, e);
      end
    end
    wr_ba = 2'b01;
  endtask

  task automatic test_watchdog();
    logic [29:0] rows [$];
    logic [21:0] e;
    rows.push_back(row(S_WQ, e_wr()));
`ifdef SDRAM_ARBIT_WDOG_EN
    repeat (1022) rows.push_back(row(S_NONE, e_wr()));
    rows.push_back(row(S_NONE, E_ARB));
`else
    repeat (2000) rows.push_back(row(S_NONE, e_wr()));
    rows.push_back(row(S_WE, E_ARB));
`endif
    rows.push_back(row(S_NONE, E_ARB));
    for (int i = 0; i < rows.size(); i++) begin
      apply(rows[i][29:22]);
      exp_q.push_back(rows[i][21:0]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL watchdog[%0d] got %h want %h", i, obs, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_no_preempt();
    test_reset_mid();
    test_watchdog();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sdram_arbit.md
SDRAM_ARBIT -- requirements
Module: sdram_arbit

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have ports flag_init_end input 1, init_cmd input 4, init_addr input 13: init sequencer done flag, its command and its address.
REQ-004 SHALL have ports aref_req input 1, flag_aref_end input 1, aref_cmd input 4, aref_addr input 13: refresh request, done flag, command and address.
REQ-005 SHALL have ports wr_req input 1, flag_wr_end input 1, wr_cmd input 4, wr_addr input 13, wr_ba input 2: write requester signals.
REQ-006 SHALL have ports rd_req input 1, flag_rd_end input 1, rd_cmd input 4, rd_addr input 13, rd_ba input 2: read requester signals.
REQ-007 SHALL have ports aref_en, wr_en, rd_en, each output 1: grant to the matching requester, held high for the whole granted operation.
REQ-008 SHALL have ports sdram_cmd output 4 ({CS_N,RAS_N,CAS_N,WE_N}), sdram_addr output 13, sdram_ba output 2: the muxed SDRAM bus.
REQ-009 SHALL have parameter CMD_NOP, default 4'b0111, meaning the command driven when no owner holds the bus.

Function
REQ-010 SHALL implement a Moore FSM with states INIT, ARBIT, AREF, WRITE, READ; the state register SHALL be the only sequential element besides the optional one in REQ-024.
REQ-011 INIT SHALL move to ARBIT on the first edge where flag_init_end=1; flag_init_end is ignored in every other state.
REQ-012 ARBIT SHALL grant with fixed priority aref_req > wr_req > rd_req, moving to AREF, WRITE or READ on the next edge; with no request it SHALL stay in ARBIT.
REQ-013 AREF, WRITE and READ SHALL return to ARBIT on the edge where their own end flag (flag_aref_end, flag_wr_end, flag_rd_end) is 1. End flags from non-owning requesters SHALL be ignored.
REQ-014 aref_en SHALL be 1 iff state=AREF; wr_en iff state=WRITE; rd_en iff state=READ; decoded from the state register only, no combinational path from inputs. At most one enable is high in any cycle.
REQ-015 Grant latency: a request seen in ARBIT at edge N SHALL raise its enable in the cycle after edge N. Each operation SHALL be followed by at least one ARBIT cycle.
REQ-016 A request that arrives while another operation runs SHALL NOT preempt it; it is evaluated in the next ARBIT cycle. Requesters hold req high until granted.
REQ-017 Bus mux, combinational on state: INIT -> init_cmd/init_addr/ba 2'b00; AREF -> aref_cmd/aref_addr/2'b00; WRITE -> wr_cmd/wr_addr/wr_ba; READ -> rd_cmd/rd_addr/rd_ba; ARBIT -> CMD_NOP/13'd0/2'b00.
REQ-018 Simultaneous aref_req, wr_req and rd_req in ARBIT SHALL grant AREF; wr_req and rd_req only SHALL grant WRITE; the losers stay pending.
REQ-019 An end flag and a new request in the same cycle SHALL go to ARBIT first, then to the grant.

Reset
REQ-020 While rst=1 the state SHALL be INIT, and aref_en, wr_en and rd_en SHALL be 0.
REQ-021 While rst=1, sdram_cmd/sdram_addr/sdram_ba SHALL follow init_cmd/init_addr/2'b00.
REQ-022 Reset asserted mid-operation (any state) SHALL force INIT immediately and drop all enables, without waiting for an end flag.
REQ-023 After rst deasserts, the FSM SHALL wait in INIT for flag_init_end again.

Configuration
REQ-024 With macro SDRAM_ARBIT_WDOG_EN defined, a 10-bit counter SHALL count cycles in AREF/WRITE/READ, clear in ARBIT/INIT, and force the state to ARBIT after 1023 cycles without an end flag. Without the macro, no counter SHALL exist and those states SHALL wait indefinitely.

Verification
REQ-025 rst=1 for 3 cycles, then rst=0 with flag_init_end=0 for 20 cycles -> all enables 0, sdram_cmd=init_cmd every cycle; flag_init_end=1 -> next cycle sdram_cmd=4'b0111, sdram_addr=0.
REQ-026 In ARBIT, aref_req=wr_req=rd_req=1 in one cycle -> aref_en=1 next cycle, sdram_addr=aref_addr; flag_aref_end after 7 cycles -> one ARBIT cycle, then wr_en=1; after flag_wr_end -> one ARBIT cycle, then rd_en=1.
REQ-027 wr_req raised while state=READ -> wr_en stays 0 until flag_rd_end, then rises 2 cycles after flag_rd_end; flag_wr_end pulsed during READ -> state unchanged.
REQ-028 rst pulsed for 1 cycle while wr_en=1, wr_ba=2'b11 -> wr_en=0 immediately, sdram_ba=2'b00, FSM waits in INIT for flag_init_end.
REQ-029 With SDRAM_ARBIT_WDOG_EN defined, grant WRITE and never assert flag_wr_end -> wr_en falls after exactly 1023 cycles in WRITE; without the macro, wr_en stays 1 for 2000 cycles.
